// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle multiply/divide unit with HI/LO registers.
//               Each operation is computed in full when it is issued and held
//               in pending registers. The HI/LO update is delayed by a
//               configurable busy latency so that it matches the pipeline's
//               stall timing.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             cancel,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CW         = $clog2(C_MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [C_CW-1:0]   r_cnt;
    logic [C_CW-1:0]   w_cnt_next;
    logic              r_busy;
    logic              r_nowrite;
    logic [WIDTH-1:0]  r_ph;
    logic [WIDTH-1:0]  r_pl;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;

    logic              w_issue;
    logic              w_run_op;
    logic              w_done;

    // Product: operands are widened to 2*WIDTH (sign- or zero-extended), so
    // the low 2*WIDTH bits of the product are correct in both modes.
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;

    // Signed divide is done on magnitudes, and the signs are fixed up
    // afterwards. This gives truncation toward zero, a remainder that takes
    // the dividend's sign, and MIN/-1 -> (MIN, 0) without a special case.
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_b_div;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Arithmetic datapath for the operation being issued
    always_comb begin
        w_signed = ~op[0];
        w_a_ext  = w_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        w_b_ext  = w_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        w_prod   = w_a_ext * w_b_ext;

        w_a_neg  = w_signed & a[WIDTH-1];
        w_b_neg  = w_signed & b[WIDTH-1];
        w_a_mag  = w_a_neg ? -a : a;
        w_b_mag  = w_b_neg ? -b : b;
        // A zero divisor is replaced by one so that the divider never sees a
        // zero. Its result is then discarded at completion.
        w_b_div  = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
        w_q_mag  = w_a_mag / w_b_div;
        w_r_mag  = w_a_mag % w_b_div;
        w_quo    = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
        w_rem    = w_a_neg ? -w_r_mag : w_r_mag;
    end

    // Next-state and counter logic. Cancel takes priority over issue and completion.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_issue      = (r_state == S_IDLE) && start && !cancel;
        w_run_op     = w_issue && !op[2];
        w_done       = (r_state == S_RUN) && (r_cnt == C_CW'(1)) && !cancel;
        if (cancel) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_run_op) begin
                        w_state_next = S_RUN;
                        w_cnt_next   = op[1] ? C_CW'(DIV_CYCLES) : C_CW'(MULT_CYCLES);
                    end
                end
                S_RUN: begin
                    w_cnt_next = r_cnt - C_CW'(1);
                    if (r_cnt == C_CW'(1)) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter, busy flag, pending result and HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_nowrite <= 1'b0;
            r_ph      <= '0;
            r_pl      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_busy <= (w_state_next == S_RUN);
            if (w_run_op) begin
                r_nowrite <= op[1] && (b == '0);
                if (op[1]) begin
                    r_ph <= w_rem;
                    r_pl <= w_quo;
                end else begin
                    r_ph <= w_prod[2*WIDTH-1:WIDTH];
                    r_pl <= w_prod[WIDTH-1:0];
                end
            end
            if (w_done && !r_nowrite) begin
                r_hi <= r_ph;
                r_lo <= r_pl;
            end
            if (w_issue && (op == 3'b100)) begin
                r_hi <= a;
            end
            if (w_issue && (op == 3'b101)) begin
                r_lo <= a;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_unit
// Description : Self-checking testbench for mdu_unit. Expected HI/LO pairs are
//               queued when an operation is issued and compared on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         cancel;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int vectors;
    int miscompares;
    logic [2*W-1:0] exp_q[$];

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .cancel (cancel),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a MULT/DIV, push the expected result, then count busy cycles and
    // compare against the popped expectation.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input int cyc);
        int n;
        logic [2*W-1:0] e;
        exp_q.push_back({eh, el});
        start = 1'b1; op = o; a = va; b = vb;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, W'(n), W'(cyc));
        e = exp_q.pop_front();
        check({tag, "_hi"}, hi, e[2*W-1:W]);
        check({tag, "_lo"}, lo, e[W-1:0]);
    endtask

    task automatic mtxx(input logic [2:0] o, input logic [W-1:0] v);
        start = 1'b1; op = o; a = v; b = '0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic signed [2*W-1:0] sp;
        logic [2*W-1:0] up;
        vectors = 0; miscompares = 0;
        reset_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'b110; a = '0; b = '0;
        tick(); tick();
        check("reset_busy", {{(W-1){1'b0}}, busy}, '0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        reset_n = 1'b1;
        tick();

        // Reset asserted in the middle of a DIV
        mtxx(3'b100, 32'h0000_0055);
        check("pre_reset_hi", hi, 32'h0000_0055);
        start = 1'b1; op = 3'b010; a = 32'd7; b = 32'd2;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_busy", {{(W-1){1'b0}}, busy}, '0);
        check("async_reset_hi", hi, '0);
        check("async_reset_lo", lo, '0);
        tick(); tick();
        reset_n = 1'b1;
        repeat (DC + 3) tick();
        check("post_reset_hi", hi, '0);
        check("post_reset_lo", lo, '0);
        check("post_reset_busy", {{(W-1){1'b0}}, busy}, '0);

        // Directed arithmetic
        run_op("mult",  3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC);
        run_op("multu", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MC);
        run_op("div",   3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
        run_op("divu",  3'b011, 32'd7, 32'd2, 32'd1, 32'd3, DC);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DC);
        run_op("div_rpos", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DC);

        // MTHI / MTLO, then divide by zero leaves them alone
        mtxx(3'b100, 32'h0000_1234);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_busy", {{(W-1){1'b0}}, busy}, '0);
        mtxx(3'b101, 32'h0000_5678);
        check("mtlo_lo", lo, 32'h0000_5678);
        run_op("div0", 3'b010, 32'd99, 32'd0, 32'h0000_1234, 32'h0000_5678, DC);

        // Cancel on the third busy cycle of a MULT
        start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd7;
        tick();
        start = 1'b0;
        tick(); tick();
        check("cancel_busy_before", {{(W-1){1'b0}}, busy}, 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy_after", {{(W-1){1'b0}}, busy}, '0);
        repeat (MC + 2) tick();
        check("cancel_hi", hi, 32'h0000_1234);
        check("cancel_lo", lo, 32'h0000_5678);

        // Cancel overrides a same-cycle MTLO
        start = 1'b1; cancel = 1'b1; op = 3'b101; a = 32'h0000_00AA;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("cancel_mtlo_lo", lo, 32'h0000_5678);

        // Start during busy is ignored, and the original result lands on time
        exp_q.push_back({32'd2, 32'd14});
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF;
        tick();
        start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd7;
        tick();
        start = 1'b0;
        begin
            int n;
            logic [2*W-1:0] e;
            n = 3;
            while (busy === 1'b1 && n < 60) begin
                n++;
                tick();
            end
            check("ignored_start_cycles", W'(n), W'(DC));
            e = exp_q.pop_front();
            check("ignored_start_hi", hi, e[2*W-1:W]);
            check("ignored_start_lo", lo, e[W-1:0]);
        end

        // Back-to-back random operations against a reference model
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case (i % 3)
                0: begin
                    sp = $signed(ra) * $signed(rb);
                    run_op("rnd_mult", 3'b000, ra, rb, sp[2*W-1:W], sp[W-1:0], MC);
                end
                1: begin
                    up = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
                    run_op("rnd_multu", 3'b001, ra, rb, up[2*W-1:W], up[W-1:0], MC);
                end
                default: begin
                    rb = (rb >> (i * 3)) | 32'd1;
                    run_op("rnd_divu", 3'b011, ra, rb, ra % rb, ra / rb, DC);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
